serial_align_ctrl: RTL and testbench

- Framing and alignment controller for the serial-to-parallel receive path.
- Samples a 1-bit serial stream MSB-first and hunts for the COM symbol, which is 8'hBC by default.
- Declares lock after LOCK_COUNT consecutive byte-aligned COMs, then emits one aligned byte per 8 clocks with a valid pulse.
- Drops lock and re-hunts when COMs stop arriving; downstream byte consumers see only aligned data.

---
 rtl/serial_align_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_serial_align_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_align_ctrl.sv
// -----------------------------------------------------------------------------
// serial_align_ctrl
//   Framing and alignment controller for the serial-to-parallel receive path.
//   Shifts in a 1-bit stream MSB first and hunts for the COM symbol. After
//   LOCK_COUNT consecutive byte-aligned COMs it locks. While locked it emits one
//   aligned symbol every WIDTH clocks. It drops lock after MISS_LIMIT
//   consecutive non-COM symbols.
//
//   Optional build macro: COM_STRIP_EN
//     When defined, COM symbols received while locked are consumed silently.
//     They produce no VALID_OUT, and DATA_OUT/K_OUT keep their previous values.
//
// Ports
//   CLK        in   system clock, rising-edge sampling
//   RESET      in   asynchronous active-low reset
//   DATA_IN    in   serial data, MSB first, one bit per clock
//   DATA_OUT   out  [WIDTH] last aligned symbol, held between VALID_OUT pulses
//   VALID_OUT  out  one-cycle pulse when DATA_OUT is updated
//   K_OUT      out  1 when DATA_OUT holds the COM symbol
//   ACTIVE     out  1 while locked
//   ERR_OUT    out  one-cycle pulse on loss of lock
//
// state  | meaning
// SEARCH | sliding one bit per clock looking for COM
// SYNC   | COM seen, counting further aligned COMs towards lock
// LOCKED | aligned, emitting one symbol per WIDTH clocks
// -----------------------------------------------------------------------------
module serial_align_ctrl #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM       = 8'hBC,
  parameter int              LOCK_COUNT = 3,
  parameter int              MISS_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID_OUT,
  output logic             K_OUT,
  output logic             ACTIVE,
  output logic             ERR_OUT
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] COM_MAX  = CW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0]    com_cnt, com_cnt_nxt, com_inc;
  logic [MW-1:0]    miss_cnt, miss_cnt_nxt, miss_inc;
  logic             sym_done;
  logic             is_com;

  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             k_nxt;
  logic             active_nxt;
  logic             err_nxt;

  // Window including the bit sampled on this edge; every decision uses it.
  assign nxt      = {shreg[WIDTH-2:0], DATA_IN};
  assign is_com   = (nxt == COM);
  assign sym_done = (bit_cnt == BIT_LAST);

  // Saturating increments: the counters never wrap.
  assign com_inc  = (com_cnt == COM_MAX)   ? com_cnt  : com_cnt + CW'(1);
  assign miss_inc = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MW'(1);

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= SEARCH;
      shreg     <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      miss_cnt  <= '0;
      DATA_OUT  <= '0;
      VALID_OUT <= 1'b0;
      K_OUT     <= 1'b0;
      ACTIVE    <= 1'b0;
      ERR_OUT   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= nxt;
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      miss_cnt  <= miss_cnt_nxt;
      DATA_OUT  <= data_nxt;
      VALID_OUT <= valid_nxt;
      K_OUT     <= k_nxt;
      ACTIVE    <= active_nxt;
      ERR_OUT   <= err_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = sym_done ? '0 : bit_cnt + BW'(1);
    com_cnt_nxt  = com_cnt;
    miss_cnt_nxt = miss_cnt;

    case (state)
      SEARCH: begin
        if (is_com) begin
          // This COM ends a symbol, so the next bit starts a fresh symbol.
          bit_cnt_nxt = '0;
          com_cnt_nxt = CW'(1);
          if (LOCK_COUNT <= 1) begin
            state_nxt    = LOCKED;
            miss_cnt_nxt = '0;
          end else begin
            state_nxt = SYNC;
          end
        end
      end

      SYNC: begin
        if (sym_done) begin
          if (is_com) begin
            com_cnt_nxt = com_inc;
            if (int'(com_cnt) + 1 >= LOCK_COUNT) begin
              state_nxt    = LOCKED;
              miss_cnt_nxt = '0;
            end
          end else begin
            state_nxt   = SEARCH;
            com_cnt_nxt = '0;
          end
        end
      end

      LOCKED: begin
        if (sym_done) begin
          if (is_com) begin
            miss_cnt_nxt = '0;
          end else begin
            miss_cnt_nxt = miss_inc;
            if (miss_inc == MISS_MAX) begin
              state_nxt   = SEARCH;
              com_cnt_nxt = '0;
            end
          end
        end
      end

      default: begin
        state_nxt   = SEARCH;
        com_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic (values registered on the same edge as the state)
  always_comb begin
    data_nxt   = DATA_OUT;
    k_nxt      = K_OUT;
    valid_nxt  = 1'b0;
    active_nxt = (state_nxt == LOCKED);
    err_nxt    = (state == LOCKED) && (state_nxt == SEARCH);

    // The symbol that causes loss of lock is still emitted.
    if (state == LOCKED && sym_done) begin
`ifdef COM_STRIP_EN
      if (!is_com) begin
        data_nxt  = nxt;
        k_nxt     = 1'b0;
        valid_nxt = 1'b1;
      end
`else
      data_nxt  = nxt;
      k_nxt     = is_com;
      valid_nxt = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_serial_align_ctrl.sv
module tb_serial_align_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       DATA_IN = 1'b0;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT;
  logic       K_OUT;
  logic       ACTIVE;
  logic       ERR_OUT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] vq[$];
  logic       kq[$];
  int         vcyc[$];
  int         err_n;
  logic       err_valid;
  int         act_cyc;
  logic       act_prev;

  serial_align_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT),
    .K_OUT     (K_OUT),
    .ACTIVE    (ACTIVE),
    .ERR_OUT   (ERR_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    vq.delete();
    kq.delete();
    vcyc.delete();
    err_n     = 0;
    err_valid = 1'b0;
    act_cyc   = -1;
    act_prev  = 1'b0;
  endtask

  // Drive one bit, let the edge sample it, then log the registered outputs.
  task automatic send_bit(input logic b);
    DATA_IN = b;
    @(posedge CLK);
    #1;
    cyc++;
    if (VALID_OUT === 1'b1) begin
      vq.push_back(DATA_OUT);
      kq.push_back(K_OUT);
      vcyc.push_back(cyc);
    end
    if (ERR_OUT === 1'b1) begin
      err_n++;
      err_valid = VALID_OUT;
    end
    if (ACTIVE === 1'b1 && act_prev !== 1'b1) act_cyc = cyc;
    act_prev = ACTIVE;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      DATA_IN = ~DATA_IN;
      @(negedge CLK);
    end
    RESET = 1'b1;
    clear_log();
  endtask

  task automatic lock3();
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
  endtask

  logic [7:0] exp_d[$];
  logic       exp_k[$];

  initial begin
    clear_log();

    // ---------- reset state with DATA_IN and CLK toggling ----------
    for (int i = 0; i < 4; i++) begin
      DATA_IN = ~DATA_IN;
      @(posedge CLK);
    end
    #1;
    check_val("rst_data",   DATA_OUT,  8'h00);
    check_val("rst_valid",  VALID_OUT, 0);
    check_val("rst_k",      K_OUT,     0);
    check_val("rst_active", ACTIVE,    0);
    check_val("rst_err",    ERR_OUT,   0);

    // ---------- lock: 1,0,1 then BC BC BC F7 3D ----------
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC); send_byte(8'hBC);
    check_val("lock_active_before", ACTIVE, 0);
    send_byte(8'hBC);
    check_val("lock_active_after", ACTIVE, 1);
    check_val("lock_no_com_emit", vq.size(), 0);
    send_byte(8'hF7); send_byte(8'h3D);
    check_val("lock_nvalid", vq.size(), 2);
    if (vq.size() == 2) begin
      check_val("lock_d0", vq[0], 8'hF7);
      check_val("lock_d1", vq[1], 8'h3D);
      check_val("lock_k0", kq[0], 0);
      check_val("lock_k1", kq[1], 0);
      check_val("lock_first_lat", vcyc[0] - act_cyc, 8);
      check_val("lock_spacing", vcyc[1] - vcyc[0], 8);
    end

    // ---------- failed sync: BC BC 55 BC BC BC 0C ----------
    do_reset();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h55);
    check_val("fsync_active_55", ACTIVE, 0);
    send_byte(8'hBC); send_byte(8'hBC);
    check_val("fsync_active_2nd", ACTIVE, 0);
    send_byte(8'hBC);
    check_val("fsync_active_3rd", ACTIVE, 1);
    send_byte(8'h0C);
    check_val("fsync_nvalid", vq.size(), 1);
    check_val("fsync_data", (vq.size() > 0) ? vq[0] : 8'hxx, 8'h0C);
    check_val("fsync_k", (kq.size() > 0) ? kq[0] : 1'bx, 0);

    // ---------- loss of lock: lock, 11 22 33 44, then 55 ----------
    do_reset();
    lock3();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check_val("loss_active_33", ACTIVE, 1);
    check_val("loss_err_early", err_n, 0);
    send_byte(8'h44);
    check_val("loss_nvalid", vq.size(), 4);
    check_val("loss_d3", (vq.size() > 3) ? vq[3] : 8'hxx, 8'h44);
    check_val("loss_err_n", err_n, 1);
    check_val("loss_err_with_valid", err_valid, 1);
    check_val("loss_active_after", ACTIVE, 0);
    send_byte(8'h55);
    check_val("loss_no_more", vq.size(), 4);

    // ---------- in-lock COM: lock, 11 22 33 BC 55 66 77 ----------
    do_reset();
    lock3();
    exp_d = '{8'h11, 8'h22, 8'h33, 8'hBC, 8'h55, 8'h66, 8'h77};
    for (int i = 0; i < exp_d.size(); i++) begin
      send_byte(exp_d[i]);
      check_val("inlock_active", ACTIVE, 1);
    end
    check_val("inlock_err", err_n, 0);
`ifdef COM_STRIP_EN
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h55, 8'h66, 8'h77};
    exp_k = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_k = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    check_val("inlock_nvalid", vq.size(), exp_d.size());
    if (vq.size() == exp_d.size()) begin
      for (int i = 0; i < exp_d.size(); i++) begin
        check_val("inlock_data", vq[i], exp_d[i]);
        check_val("inlock_k", kq[i], exp_k[i]);
      end
    end

    // ---------- async reset mid-operation, during a VALID_OUT pulse ----------
    do_reset();
    lock3();
    send_byte(8'h5A);
    check_val("areset_pre_valid", VALID_OUT, 1);
    check_val("areset_pre_data", DATA_OUT, 8'h5A);
    #2;
    RESET = 1'b0;
    #1;
    check_val("areset_data",   DATA_OUT,  8'h00);
    check_val("areset_valid",  VALID_OUT, 0);
    check_val("areset_k",      K_OUT,     0);
    check_val("areset_active", ACTIVE,    0);
    check_val("areset_err",    ERR_OUT,   0);
    for (int i = 0; i < 3; i++) begin
      DATA_IN = ~DATA_IN;
      @(posedge CLK);
    end
    #1;
    check_val("areset_hold_active", ACTIVE, 0);
    check_val("areset_hold_valid", VALID_OUT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    clear_log();
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h11);
    check_val("areset_relock_none", vq.size(), 0);
    check_val("areset_relock_active", ACTIVE, 0);
    lock3();
    send_byte(8'h77);
    check_val("areset_relock_nvalid", vq.size(), 1);
    check_val("areset_relock_data", (vq.size() > 0) ? vq[0] : 8'hxx, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
